// File: rtl/sp_mem_arbiter_if.sv
// Scratchpad-to-memory arbiter bus: scratchpad load/store requests and the single memory port.
// master = requester/memory environment side, slave = arbiter side.
interface sp_mem_arbiter_if #(
   parameter int unsigned WORD_W       = 32,
   parameter int unsigned BITS_PER_ROW = 64,
   parameter int unsigned ROW_S_W      = 2
);
   // scratchpad request side
   logic                    sLoad;
   logic                    sStore;
   logic [WORD_W-1:0]       load_addr;
   logic [WORD_W-1:0]       store_addr;
   logic [BITS_PER_ROW-1:0] store_data;
   logic [BITS_PER_ROW-1:0] load_data;
   logic                    sLoad_hit;
   logic                    sStore_hit;
   logic [ROW_S_W-1:0]      sLoad_row;

   // memory side
   logic                    mem_req;
   logic                    mem_we;
   logic [WORD_W-1:0]       mem_addr;
   logic [BITS_PER_ROW-1:0] mem_wdata;
   logic                    mem_ready;
   logic [BITS_PER_ROW-1:0] mem_rdata;

   modport master (
      output sLoad, sStore, load_addr, store_addr, store_data, mem_ready, mem_rdata,
      input  load_data, sLoad_hit, sStore_hit, sLoad_row,
      input  mem_req, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  sLoad, sStore, load_addr, store_addr, store_data, mem_ready, mem_rdata,
      output load_data, sLoad_hit, sStore_hit, sLoad_row,
      output mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/sp_mem_arbiter.sv
// Single-outstanding arbiter between scratchpad load/store requests and one memory port.
// Define SP_ARB_RR_EN for round-robin on simultaneous requests; otherwise load has fixed priority.
module sp_mem_arbiter #(
   parameter int unsigned WORD_W       = 32,
   parameter int unsigned BITS_PER_ROW = 64,
   parameter int unsigned ROW_S_W      = 2
) (
   input  logic            CLK,
   input  logic            RST,
   sp_mem_arbiter_if.slave bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] STORE = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   logic [1:0]              state_q, state_d;
   logic                    mem_req_q, mem_req_d;
   logic                    mem_we_q, mem_we_d;
   logic [WORD_W-1:0]       mem_addr_q, mem_addr_d;
   logic [BITS_PER_ROW-1:0] mem_wdata_q, mem_wdata_d;
   logic [BITS_PER_ROW-1:0] load_data_q, load_data_d;
   logic [ROW_S_W-1:0]      pend_row_q, pend_row_d;
   logic [ROW_S_W-1:0]      load_row_q, load_row_d;
   logic                    load_hit_q, load_hit_d;
   logic                    store_hit_q, store_hit_d;
   logic                    grant_load_c;
   logic                    grant_store_c;

`ifdef SP_ARB_RR_EN
   // Set when the most recent grant went to a store; favours load on the next collision.
   logic last_store_q, last_store_d;
   assign grant_load_c  = bus.sLoad & (~bus.sStore | last_store_q);
`else
   assign grant_load_c  = bus.sLoad;
`endif
   assign grant_store_c = bus.sStore & ~grant_load_c;

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      load_data_d = load_data_q;
      pend_row_d  = pend_row_q;
      load_row_d  = load_row_q;
      load_hit_d  = 1'b0;
      store_hit_d = 1'b0;
`ifdef SP_ARB_RR_EN
      last_store_d = last_store_q;
`endif
      case (state_q)
         IDLE: begin
            if (grant_load_c) begin
               state_d    = LOAD;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = bus.load_addr;
               pend_row_d = bus.load_addr[ROW_S_W-1:0];
`ifdef SP_ARB_RR_EN
               last_store_d = 1'b0;
`endif
            end else if (grant_store_c) begin
               state_d     = STORE;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = bus.store_addr;
               mem_wdata_d = bus.store_data;
`ifdef SP_ARB_RR_EN
               last_store_d = 1'b1;
`endif
            end
         end
         LOAD: begin
            if (bus.mem_ready) begin
               state_d     = RESP;
               mem_req_d   = 1'b0;
               load_data_d = bus.mem_rdata;
               load_row_d  = pend_row_q;
               load_hit_d  = 1'b1;
            end
         end
         STORE: begin
            if (bus.mem_ready) begin
               state_d     = RESP;
               mem_req_d   = 1'b0;
               mem_we_d    = 1'b0;
               store_hit_d = 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset abandons any transaction in flight
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         load_data_q <= '0;
         pend_row_q  <= '0;
         load_row_q  <= '0;
         load_hit_q  <= 1'b0;
         store_hit_q <= 1'b0;
`ifdef SP_ARB_RR_EN
         last_store_q <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         load_data_q <= load_data_d;
         pend_row_q  <= pend_row_d;
         load_row_q  <= load_row_d;
         load_hit_q  <= load_hit_d;
         store_hit_q <= store_hit_d;
`ifdef SP_ARB_RR_EN
         last_store_q <= last_store_d;
`endif
      end
   end

   assign bus.mem_req    = mem_req_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.load_data  = load_data_q;
   assign bus.sLoad_row  = load_row_q;
   assign bus.sLoad_hit  = load_hit_q;
   assign bus.sStore_hit = store_hit_q;

endmodule

// File: tb/tb_sp_mem_arbiter.sv
// Directed, table-driven bench for sp_mem_arbiter plus hand sequences for arbitration,
// reset mid-transaction and back-to-back load timing.
module tb_sp_mem_arbiter;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   sp_mem_arbiter_if #(.WORD_W(32), .BITS_PER_ROW(64), .ROW_S_W(2)) bus ();

   sp_mem_arbiter #(.WORD_W(32), .BITS_PER_ROW(64), .ROW_S_W(2)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        is_load;
      logic [31:0] addr;
      logic [63:0] data;      // store data, or memory read data for a load
      int          waits;     // cycles mem_ready is held low
      logic [31:0] exp_addr;
      logic        exp_we;
      logic [63:0] exp_ldata; // load_data after the transaction
      logic [1:0]  exp_row;   // sLoad_row after the transaction
   } vec_t;

   vec_t vecs[5];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, ".mem_req"},    64'(bus.mem_req),    64'd0);
      chk({nm, ".mem_we"},     64'(bus.mem_we),     64'd0);
      chk({nm, ".mem_addr"},   64'(bus.mem_addr),   64'd0);
      chk({nm, ".mem_wdata"},  bus.mem_wdata,       64'd0);
      chk({nm, ".load_data"},  bus.load_data,       64'd0);
      chk({nm, ".sLoad_row"},  64'(bus.sLoad_row),  64'd0);
      chk({nm, ".sLoad_hit"},  64'(bus.sLoad_hit),  64'd0);
      chk({nm, ".sStore_hit"}, 64'(bus.sStore_hit), 64'd0);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      string nm;
      nm = $sformatf("vec%0d", idx);
      if (v.is_load) begin
         bus.sLoad     = 1'b1;
         bus.load_addr = v.addr;
      end else begin
         bus.sStore     = 1'b1;
         bus.store_addr = v.addr;
         bus.store_data = v.data;
      end
      bus.mem_ready = 1'b0;
      step();
      for (int c = 0; c <= v.waits; c++) begin
         chk({nm, ".mem_req"},  64'(bus.mem_req),  64'd1);
         chk({nm, ".mem_we"},   64'(bus.mem_we),   64'(v.exp_we));
         chk({nm, ".mem_addr"}, 64'(bus.mem_addr), 64'(v.exp_addr));
         if (!v.is_load) chk({nm, ".mem_wdata"}, bus.mem_wdata, v.data);
         chk({nm, ".hit_early"}, 64'(bus.sLoad_hit | bus.sStore_hit), 64'd0);
         bus.mem_ready = (c == v.waits);
         if (c == v.waits && v.is_load) bus.mem_rdata = v.data;
         step();
      end
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 64'h5555_AAAA_5555_AAAA;
      chk({nm, ".resp_req"},   64'(bus.mem_req),    64'd0);
      chk({nm, ".sLoad_hit"},  64'(bus.sLoad_hit),  64'(v.is_load));
      chk({nm, ".sStore_hit"}, 64'(bus.sStore_hit), 64'(!v.is_load));
      bus.sLoad  = 1'b0;
      bus.sStore = 1'b0;
      step();
      chk({nm, ".idle_hits"}, 64'(bus.sLoad_hit | bus.sStore_hit), 64'd0);
      chk({nm, ".idle_req"},  64'(bus.mem_req),   64'd0);
      chk({nm, ".load_data"}, bus.load_data,      v.exp_ldata);
      chk({nm, ".sLoad_row"}, 64'(bus.sLoad_row), 64'(v.exp_row));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      bus.sLoad      = 1'b0;
      bus.sStore     = 1'b0;
      bus.load_addr  = '0;
      bus.store_addr = '0;
      bus.store_data = '0;
      bus.mem_ready  = 1'b0;
      bus.mem_rdata  = '0;

      vecs[0] = '{1'b1, 32'h0000_0102, 64'hDEAD_BEEF_0123_4567, 0,
                  32'h0000_0102, 1'b0, 64'hDEAD_BEEF_0123_4567, 2'd2};
      vecs[1] = '{1'b0, 32'h0000_0040, 64'hA5A5_A5A5_A5A5_A5A5, 3,
                  32'h0000_0040, 1'b1, 64'hDEAD_BEEF_0123_4567, 2'd2};
      vecs[2] = '{1'b1, 32'hFFFF_FFFF, 64'h0123_4567_89AB_CDEF, 1,
                  32'hFFFF_FFFF, 1'b0, 64'h0123_4567_89AB_CDEF, 2'd3};
      vecs[3] = '{1'b0, 32'h8000_0000, 64'h0000_0000_0000_0001, 0,
                  32'h8000_0000, 1'b1, 64'h0123_4567_89AB_CDEF, 2'd3};
      vecs[4] = '{1'b1, 32'h0000_0004, 64'hFFFF_0000_FFFF_0000, 2,
                  32'h0000_0004, 1'b0, 64'hFFFF_0000_FFFF_0000, 2'd0};

      // reset values
      rst = 1'b1;
      step();
      step();
      chk_all_zero("reset");
      rst = 1'b0;
      step();
      chk_all_zero("idle_noreq");

      for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

      // simultaneous requests held across two transactions
      do_reset();
      bus.sLoad      = 1'b1;
      bus.load_addr  = 32'h10;
      bus.sStore     = 1'b1;
      bus.store_addr = 32'h20;
      bus.store_data = 64'h1234_5678_9ABC_DEF0;
      bus.mem_rdata  = 64'h0BAD_F00D_0000_0010;
      step();
      chk("both1.mem_we",   64'(bus.mem_we),   64'd0);
      chk("both1.mem_addr", 64'(bus.mem_addr), 64'h10);
      bus.mem_ready = 1'b1;
      step();
      bus.mem_ready = 1'b0;
      chk("both1.sLoad_hit",  64'(bus.sLoad_hit),  64'd1);
      chk("both1.sStore_hit", 64'(bus.sStore_hit), 64'd0);
      step();
      chk("both.idle_req", 64'(bus.mem_req), 64'd0);
      step();
      chk("both2.mem_req", 64'(bus.mem_req), 64'd1);
`ifdef SP_ARB_RR_EN
      chk("both2.mem_we",   64'(bus.mem_we),   64'd1);
      chk("both2.mem_addr", 64'(bus.mem_addr), 64'h20);
      chk("both2.mem_wdata", bus.mem_wdata,    64'h1234_5678_9ABC_DEF0);
      bus.mem_ready = 1'b1;
      step();
      bus.mem_ready = 1'b0;
      chk("both2.sStore_hit", 64'(bus.sStore_hit), 64'd1);
      chk("both2.sLoad_hit",  64'(bus.sLoad_hit),  64'd0);
      bus.sLoad  = 1'b0;
      bus.sStore = 1'b0;
      step();
`else
      chk("both2.mem_we",   64'(bus.mem_we),   64'd0);
      chk("both2.mem_addr", 64'(bus.mem_addr), 64'h10);
      bus.mem_ready = 1'b1;
      step();
      bus.mem_ready = 1'b0;
      chk("both2.sLoad_hit",  64'(bus.sLoad_hit),  64'd1);
      chk("both2.sStore_hit", 64'(bus.sStore_hit), 64'd0);
      bus.sLoad = 1'b0;
      step();
      step();
      chk("both3.mem_we",   64'(bus.mem_we),   64'd1);
      chk("both3.mem_addr", 64'(bus.mem_addr), 64'h20);
      bus.mem_ready = 1'b1;
      step();
      bus.mem_ready = 1'b0;
      chk("both3.sStore_hit", 64'(bus.sStore_hit), 64'd1);
      bus.sStore = 1'b0;
      step();
`endif
      chk("both.end_hits", 64'(bus.sLoad_hit | bus.sStore_hit), 64'd0);

      // reset while a load waits on memory
      bus.sLoad     = 1'b1;
      bus.load_addr = 32'h7;
      bus.mem_ready = 1'b0;
      step();
      chk("rstload.mem_req", 64'(bus.mem_req), 64'd1);
      rst = 1'b1;
      bus.mem_ready = 1'b1;
      step();
      chk_all_zero("rstload");
      rst = 1'b0;
      bus.sLoad     = 1'b0;
      bus.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rstload.after_hit", 64'(bus.sLoad_hit), 64'd0);
         chk("rstload.after_req", 64'(bus.mem_req),   64'd0);
      end

      // back-to-back loads with memory always ready
      bus.sLoad     = 1'b1;
      bus.load_addr = 32'h1;
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 64'h1111_1111_1111_1111;
      for (int i = 1; i <= 7; i++) begin
         step();
         chk($sformatf("b2b.c%0d.mem_req", i),   64'(bus.mem_req),   64'(i == 1 || i == 4));
         chk($sformatf("b2b.c%0d.sLoad_hit", i), 64'(bus.sLoad_hit), 64'(i == 2 || i == 5));
         if (i == 1) chk("b2b.addr1", 64'(bus.mem_addr), 64'h1);
         if (i == 4) chk("b2b.addr2", 64'(bus.mem_addr), 64'h3);
         if (i == 2) begin
            chk("b2b.row1",  64'(bus.sLoad_row), 64'd1);
            chk("b2b.data1", bus.load_data,      64'h1111_1111_1111_1111);
            bus.load_addr = 32'h3;
            bus.mem_rdata = 64'h3333_3333_3333_3333;
         end
         if (i == 5) begin
            chk("b2b.row2",  64'(bus.sLoad_row), 64'd3);
            chk("b2b.data2", bus.load_data,      64'h3333_3333_3333_3333);
            bus.sLoad = 1'b0;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sp_mem_arbiter.md
SP_MEM_ARBITER -- requirements
Module: sp_mem_arbiter

Interface
REQ-001 SHALL take parameter WORD_W, default 32, address width of load_addr/store_addr/mem_addr.
REQ-002 SHALL take parameter BITS_PER_ROW, default 64, width of one scratchpad row and of the memory data bus.
REQ-003 SHALL take parameter ROW_S_W, default 2, width of the row tag returned on sLoad_row.
REQ-004 SHALL have one clock and a synchronous, active-high reset.
REQ-005 CLK  in  1  sole clock; all state updates on rising edge.
REQ-006 RST  in  1  synchronous active-high reset.
REQ-007 sLoad  in  1  scratchpad load request, level-held until sLoad_hit.
REQ-008 sStore  in  1  scratchpad store request, level-held until sStore_hit.
REQ-009 load_addr  in  WORD_W  load address, stable while sLoad=1.
REQ-010 store_addr  in  WORD_W  store address, stable while sStore=1.
REQ-011 store_data  in  BITS_PER_ROW  store row data, stable while sStore=1.
REQ-012 load_data  out  BITS_PER_ROW  registered load result.
REQ-013 sLoad_hit  out  1  one-cycle load-complete pulse.
REQ-014 sStore_hit  out  1  one-cycle store-complete pulse.
REQ-015 sLoad_row  out  ROW_S_W  destination row tag of load_data.
REQ-016 mem_req  out  1  memory request, held until mem_ready.
REQ-017 mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
REQ-018 mem_addr  out  WORD_W  registered request address.
REQ-019 mem_wdata  out  BITS_PER_ROW  registered write data.
REQ-020 mem_ready  in  1  memory accepts/completes the current request this cycle.
REQ-021 mem_rdata  in  BITS_PER_ROW  read data, valid when mem_ready=1 and mem_we=0.

Function
REQ-022 SHALL implement FSM states IDLE, LOAD, STORE, RESP; one transaction outstanding at a time.
REQ-023 In IDLE with exactly one request asserted, SHALL grant it, register address/data (and load_addr[ROW_S_W-1:0] as row tag), and enter LOAD or STORE next cycle.
REQ-024 In IDLE with both requests asserted, SHALL grant per the policy in Configuration.
REQ-025 In LOAD/STORE, SHALL drive mem_req=1, mem_we=(state==STORE), mem_addr/mem_wdata from registers; all request inputs ignored.
REQ-026 In LOAD/STORE with mem_ready=0, SHALL hold state and all mem_* outputs stable.
REQ-027 In LOAD with mem_ready=1, SHALL capture mem_rdata into load_data and enter RESP; in STORE with mem_ready=1, SHALL enter RESP.
REQ-028 In RESP, SHALL assert exactly one of sLoad_hit/sStore_hit for one cycle, matching the completed transaction, with mem_req=0, then return to IDLE.
REQ-029 load_data and sLoad_row SHALL remain valid from the sLoad_hit cycle until the next load completes.
REQ-030 Minimum latency: request seen in IDLE at cycle 0, mem_req at cycle 1, hit at cycle 2 when mem_ready=1 at cycle 1; next grant possible at cycle 3.
REQ-031 In IDLE with no request, SHALL hold mem_req=0 and both hit outputs 0.

Reset
REQ-032 On RST=1 at a clock edge, SHALL enter IDLE and clear mem_req, mem_we, mem_addr, mem_wdata, load_data, sLoad_row, sLoad_hit, sStore_hit to 0; last-grant flag to "store".
REQ-033 RST during LOAD/STORE/RESP SHALL abandon the transaction with no hit pulse; mem_req SHALL be 0 in the cycle after the reset edge.
REQ-034 RST SHALL take priority over all other events in the same cycle.

Configuration
REQ-035 Macro SP_ARB_RR_EN SHALL select the simultaneous-request policy.
REQ-036 With SP_ARB_RR_EN defined: round-robin; grant the type not granted most recently (load first after reset); flag updates on every grant.
REQ-037 Without SP_ARB_RR_EN: fixed priority; load always wins; last-grant flag is not implemented.

Verification
REQ-038 Load: sLoad=1, load_addr=0x0000_0102, mem_ready=1 at first mem_req, mem_rdata=0xDEAD_BEEF_0123_4567 -> mem_addr=0x102, mem_we=0; sLoad_hit at cycle 2, load_data=0xDEADBEEF01234567, sLoad_row=2.
REQ-039 Store with wait states: sStore=1, store_addr=0x40, store_data=0xA5A5..., mem_ready low 3 cycles -> mem_req held 4 cycles, stable addr/data, mem_we=1; single sStore_hit after mem_ready.
REQ-040 Simultaneous sLoad/sStore held for two transactions -> with SP_ARB_RR_EN: load then store; without: load granted, then store only after sLoad drops.
REQ-041 RST asserted while in LOAD with mem_ready=0 -> next cycle IDLE, mem_req=0, no sLoad_hit, all outputs 0.
REQ-042 Back-to-back loads at addresses 0x1, 0x3 with mem_ready=1 -> hits at cycles 2 and 5, sLoad_row 1 then 3, no gaps in mem_req beyond RESP/IDLE.
